// File: rtl/updown_dir_ctrl.sv
// Direction controller for an up/down counter.
// A bouncing push-button is synchronised and debounced; each accepted press
// toggles the count direction. With auto_en set, the direction also reverses
// one cycle before the counter would reach a limit, so the counter never wraps.
module updown_dir_ctrl #(
   parameter int N         = 4,
   parameter int DB_CYCLES = 16
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         btn_raw,
   input  logic         auto_en,
   input  logic [N-1:0] count,
   output logic         up_down,
   output logic         dir_pulse,
   output logic         btn_db,
   output logic         press_pulse
);

   localparam int DBW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
   localparam logic [DBW-1:0] DB_LAST = DBW'(DB_CYCLES - 1);
   localparam logic [DBW-1:0] DB_ONE  = DBW'(1);

   // The UP turn-around happens at MAX-1 (all ones except the LSB).
   localparam logic [N-1:0] CNT_TURN_UP = {{(N-1){1'b1}}, 1'b0};
   // The DOWN turn-around happens at 1.
   localparam logic [N-1:0] CNT_TURN_DN = N'(1);

   typedef enum logic {
      ST_DOWN = 1'b0,
      ST_UP   = 1'b1
   } dir_state_t;

   logic           sync1;
   logic           sync2;
   logic [DBW-1:0] db_cnt;
   dir_state_t     state;
   dir_state_t     state_nxt;

   // Two-flop synchronizer: nothing downstream ever looks at btn_raw directly.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples the pre-edge values of its neighbours, like real hardware.
      if (!reset) begin
         sync1 <= 1'b0;
         sync2 <= 1'b0;
      end else begin
         sync1 <= btn_raw;
         sync2 <= sync1;
      end
   end

   // Debounce: accept a new level only after it has held DB_CYCLES cycles.
   always_ff @(posedge clk) begin
      if (!reset) begin
         btn_db      <= 1'b0;
         press_pulse <= 1'b0;
         db_cnt      <= '0;
      end else if (sync2 == btn_db) begin
         // Level matches the accepted one: any partial run is discarded.
         db_cnt      <= '0;
         press_pulse <= 1'b0;
      end else if (db_cnt == DB_LAST) begin
         btn_db      <= sync2;
         db_cnt      <= '0;
         press_pulse <= sync2;
      end else begin
         db_cnt      <= db_cnt + DB_ONE;
         press_pulse <= 1'b0;
      end
   end

   // Direction state register plus the change-of-direction pulse.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state     <= ST_UP;
         dir_pulse <= 1'b0;
      end else begin
         state     <= state_nxt;
         dir_pulse <= (state_nxt != state);
      end
   end

   // Next-state logic: a press and an auto-reverse in the same cycle both
   // request the same single toggle, so they can never cancel each other.
   always_comb begin
      // NOTE: default first so every path assigns state_nxt and no latch
      // is inferred.
      state_nxt = state;
      unique case (state)
         ST_UP: begin
            if (press_pulse || (auto_en && (count == CNT_TURN_UP)))
               state_nxt = ST_DOWN;
         end
         ST_DOWN: begin
            if (press_pulse || (auto_en && (count == CNT_TURN_DN)))
               state_nxt = ST_UP;
         end
         default: state_nxt = ST_UP;
      endcase
   end

   assign up_down = (state == ST_UP);

endmodule

// File: tb/tb_updown_dir_ctrl.sv
// Directed bench for updown_dir_ctrl with N=4, DB_CYCLES=4 and a behavioural
// 4-bit up/down counter closing the loop. Inputs change and outputs are
// sampled on the falling edge; expected values are hand-derived sequences.
module tb_updown_dir_ctrl;

   logic       clk = 1'b0;
   logic       reset;
   logic       btn_raw;
   logic       auto_en;
   logic [3:0] count;
   logic       up_down;
   logic       dir_pulse;
   logic       btn_db;
   logic       press_pulse;

   int checks = 0;
   int errors = 0;

   updown_dir_ctrl #(.N(4), .DB_CYCLES(4)) dut (
      .clk        (clk),
      .reset      (reset),
      .btn_raw    (btn_raw),
      .auto_en    (auto_en),
      .count      (count),
      .up_down    (up_down),
      .dir_pulse  (dir_pulse),
      .btn_db     (btn_db),
      .press_pulse(press_pulse)
   );

   always #5 clk = ~clk;

   // Downstream counter, reset in the same cycle as the controller.
   always @(posedge clk) begin
      if (!reset)       count <= 4'd0;
      else if (up_down) count <= count + 4'd1;
      else              count <= count - 4'd1;
   end

   task automatic check(input string tag, input logic [31:0] act,
                        input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   // Hold reset for n edges, check the reset state, then release.
   task automatic do_reset(input int n);
      reset = 1'b0;
      repeat (n) tick();
      check("rst_state", {count, up_down, dir_pulse, btn_db, press_pulse},
            {4'd0, 1'b1, 1'b0, 1'b0, 1'b0});
      reset = 1'b1;
   endtask

   initial begin
      logic [3:0] e_cnt;
      logic       e_ud;
      logic       e_dp;
      logic       e_pp;
      int         e;

      reset   = 1'b0;
      btn_raw = 1'b0;
      auto_en = 1'b1;
      @(negedge clk);

      // Auto-reverse bounce: 0..15,14..0,1 with a direction pulse at 15 and 0.
      do_reset(3);
      for (int k = 1; k <= 31; k++) begin
         tick();
         e     = (k <= 15) ? k : (k <= 30) ? 30 - k : k - 30;
         e_cnt = 4'(e);
         e_ud  = !(k >= 15 && k < 30);
         e_dp  = (k == 15) || (k == 30);
         check("auto_seq", {e_cnt, up_down, dir_pulse}, {count, up_down, dir_pulse} ^ 32'd0 ^ 32'd0);
         check("auto_seq", {count, up_down, dir_pulse}, {e_cnt, e_ud, e_dp});
      end

      // Short glitch (3 cycles) is rejected; a steady press lands at E+5.
      auto_en = 1'b0;
      do_reset(2);
      btn_raw = 1'b1;
      repeat (3) tick();
      btn_raw = 1'b0;
      for (int k = 0; k < 8; k++) begin
         tick();
         check("glitch", {btn_db, press_pulse, up_down}, 3'b001);
      end
      btn_raw = 1'b1;
      repeat (5) tick();
      check("no_early_accept", {btn_db, press_pulse}, 2'b00);
      tick();
      check("accept_e5", {btn_db, press_pulse, up_down}, 3'b111);
      tick();
      check("toggle_e6", {btn_db, press_pulse, up_down, dir_pulse}, 4'b1001);
      btn_raw = 1'b0;
      for (int k = 0; k < 8; k++) begin
         tick();
         check("release_no_press", {press_pulse, dir_pulse}, 2'b00);
      end
      check("release_level", {btn_db, up_down}, 2'b00);

      // Free-running with wrap: no presses, direction never changes.
      do_reset(2);
      for (int k = 1; k <= 20; k++) begin
         tick();
         e_cnt = 4'(k % 16);
         check("wrap_seq", {count, up_down, dir_pulse}, {e_cnt, 1'b1, 1'b0});
      end

      // auto_en rising while already at MAX in UP: the wrap still happens.
      do_reset(2);
      repeat (15) tick();
      check("at_max", {count, up_down}, {4'd15, 1'b1});
      auto_en = 1'b1;
      tick();
      check("late_en_wrap", {count, up_down, dir_pulse}, {4'd0, 1'b1, 1'b0});
      repeat (14) tick();
      check("late_en_14", {count, up_down}, {4'd14, 1'b1});
      tick();
      check("late_en_rev", {count, up_down, dir_pulse}, {4'd15, 1'b0, 1'b1});

      // Manual press while counting up near 5, then auto-reverse at 1.
      do_reset(2);
      btn_raw = 1'b1;
      for (int k = 1; k <= 16; k++) begin
         tick();
         e     = (k <= 7) ? k : (k <= 14) ? 14 - k : k - 14;
         e_cnt = 4'(e);
         e_ud  = !(k >= 7 && k <= 13);
         e_dp  = (k == 7) || (k == 14);
         e_pp  = (k == 6);
         check("press_mid", {count, up_down, dir_pulse, press_pulse},
               {e_cnt, e_ud, e_dp, e_pp});
      end
      btn_raw = 1'b0;
      repeat (8) tick();

      // Press pulse coincides with count==14: exactly one reversal.
      do_reset(2);
      repeat (8) tick();
      btn_raw = 1'b1;
      for (int k = 9; k <= 20; k++) begin
         tick();
         e     = (k <= 15) ? k : 30 - k;
         e_cnt = 4'(e);
         e_ud  = (k < 15);
         e_dp  = (k == 15);
         e_pp  = (k == 14);
         check("press_at_14", {count, up_down, dir_pulse, press_pulse},
               {e_cnt, e_ud, e_dp, e_pp});
      end
      btn_raw = 1'b0;
      repeat (8) tick();

      // Reset two cycles into a stable press discards debounce progress.
      do_reset(2);
      repeat (2) tick();
      btn_raw = 1'b1;
      repeat (2) tick();
      do_reset(2);
      repeat (4) tick();
      check("post_rst_t4", {btn_db, press_pulse}, 2'b00);
      tick();
      check("post_rst_t5", {btn_db, press_pulse}, 2'b00);
      tick();
      check("post_rst_accept", {btn_db, press_pulse, up_down, count},
            {1'b1, 1'b1, 1'b1, 4'd6});
      tick();
      check("post_rst_toggle", {press_pulse, up_down, dir_pulse}, 3'b001);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/updown_dir_ctrl.md
UPDOWN_DIR_CTRL -- requirements
Module: updown_dir_ctrl

Interface
REQ-001 Parameter: N, default 4, width of the count being steered; N SHALL be >= 2.
REQ-002 Parameter: DB_CYCLES, default 16, number of consecutive cycles of a changed button level needed to accept it; SHALL be >= 2.
REQ-003 clk  input  1  single system clock; all state updates on the rising edge.
REQ-004 reset  input  1  synchronous, active-low reset; sampled on the rising edge of clk.
REQ-005 btn_raw  input  1  asynchronous, bouncing direction-toggle push-button, active high.
REQ-006 auto_en  input  1  1 = auto-reverse at count limits enabled; 0 = free-running with wrap.
REQ-007 count  input  N  current registered value of the downstream up/down counter, which is reset in the same cycle as this block.
REQ-008 up_down  output  1  direction to the counter: 1 = increment, 0 = decrement; registered.
REQ-009 dir_pulse  output  1  one-cycle pulse, registered, high in the first cycle of each new up_down value.
REQ-010 btn_db  output  1  debounced button level; registered.
REQ-011 press_pulse  output  1  one-cycle pulse, registered, high in the first cycle btn_db is 1 after being 0.

Function
REQ-012 btn_raw SHALL pass through a 2-flop synchronizer (sync1, sync2) before any other use.
REQ-013 Debounce counter db_cnt, width ceil(log2(DB_CYCLES)): if sync2 == btn_db, db_cnt <= 0.
REQ-014 If sync2 != btn_db and db_cnt == DB_CYCLES-1: btn_db <= sync2, db_cnt <= 0, press_pulse <= sync2; otherwise db_cnt <= db_cnt+1, press_pulse <= 0.
REQ-015 Latency: a clean btn_raw 0->1 first sampled at edge E SHALL set btn_db and press_pulse at edge E+DB_CYCLES+1; any return to the old level before that edge restarts the count.
REQ-016 Direction FSM: two states, UP (up_down=1) and DOWN (up_down=0); MAX = 2^N-1.
REQ-017 UP -> DOWN when (auto_en==1 and count==MAX-1) or press_pulse==1; else stay UP.
REQ-018 DOWN -> UP when (auto_en==1 and count==1) or press_pulse==1; else stay DOWN.
REQ-019 Simultaneous auto-reverse condition and press_pulse SHALL produce exactly one transition; the press is consumed.
REQ-020 Auto-reverse is predictive: with auto_en=1 the counter SHALL never wrap; the sequence from reset is 0,1,...,MAX,MAX-1,...,1,0,1,...
REQ-021 With auto_en=0 only press_pulse changes state; counter wraps MAX->0 (UP) or 0->MAX (DOWN).
REQ-022 auto_en changing 0->1 while count lies at MAX (UP) or 0 (DOWN) SHALL NOT retroactively prevent the wrap already in progress; normal rules apply from the next comparison.
REQ-023 dir_pulse <= 1 on every edge where the FSM changes state, else 0.
REQ-024 Block SHALL be fully synchronous; no combinational path from count or btn_raw to any output.

Reset
REQ-025 When reset==0 at a rising edge: FSM <= UP (up_down=1), dir_pulse=0, btn_db=0, press_pulse=0, db_cnt=0, sync1=sync2=0.
REQ-026 Reset SHALL override every other event in the same cycle, including a pending debounce acceptance or transition.
REQ-027 Reset mid-debounce SHALL discard partial progress; the button must be stable a full DB_CYCLES again after release of reset.

Verification (N=4, DB_CYCLES=4, behavioural 4-bit counter model in loop)
REQ-028 Reset held 3 cycles, btn_raw=0, auto_en=1 -> up_down=1, dir_pulse=0, btn_db=0; after release count runs 0..15,14..0,1 with no wrap; dir_pulse high exactly when count reaches 15 and 0.
REQ-029 btn_raw high for 3 cycles then low -> btn_db, press_pulse, up_down unchanged; btn_raw high steady from edge E -> btn_db=press_pulse=1 at E+5, press_pulse=0 at E+6, up_down toggled at E+6.
REQ-030 UP at count=5, debounced press -> up_down=0 one edge after press_pulse; counter continues 6 (or 7), then decrements to 1 and auto-reverses to UP.
REQ-031 UP, press_pulse aligned with count==14 -> single transition to DOWN, one dir_pulse, counter peaks at 15, no wrap.
REQ-032 auto_en=0, no presses -> up_down stays 1, counter wraps 15->0, dir_pulse never asserted.
REQ-033 reset asserted 2 cycles into a stable button press -> btn_db=0, press_pulse=0, up_down=1; press accepted only after 4 further stable cycles post-reset (plus sync delay).
